// File: rtl/ddc_pkg.sv
// Shared definitions for the DDC chain: mixer latency, mode encodings and the
// round-half-up / saturate helper used by the mixer output stage.
package ddc_pkg;

    localparam int MIX_LATENCY = 4;

    typedef enum logic {
        MIX_REAL = 1'b0,
        MIX_CPLX = 1'b1
    } mix_input_e;

    typedef enum logic {
        MIX_DOWN = 1'b0,
        MIX_UP   = 1'b1
    } mix_dir_e;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } sat_round_t;

    // Wide fixed-width working type keeps the helper independent of the caller's widths.
    function automatic sat_round_t sat_round(input logic signed [63:0] value,
                                             input int                 shift,
                                             input int                 out_width);
        logic signed [63:0] rounded;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sat_round_t         res;
        rounded = value;
        if (shift > 0)
            rounded = (value + (64'sd1 <<< (shift - 1))) >>> shift;
        max_v = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_width - 1));
        res.sat = 1'b1;
        if (rounded > max_v)
            res.value = max_v;
        else if (rounded < min_v)
            res.value = min_v;
        else begin
            res.value = rounded;
            res.sat   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/ddc_round_sat.sv
// Final mixer stage for one rail: rounds the wide sum half-up, clamps it to the
// output width and registers the result together with its saturation flag.
module ddc_round_sat
    import ddc_pkg::*;
#(
    parameter int SUMBITWIDTH = 33,
    parameter int OUTBITWIDTH = 16,
    parameter int SHIFT       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic signed [SUMBITWIDTH-1:0] sum,
    output logic signed [OUTBITWIDTH-1:0] out,
    output logic                          sat_hit,
    output logic                          sat
);

    sat_round_t                 res;
    logic [63-OUTBITWIDTH:0]    unused_hi;

    always_comb begin
        res = sat_round({{(64 - SUMBITWIDTH){sum[SUMBITWIDTH-1]}}, sum}, SHIFT, OUTBITWIDTH);
    end

    // Clamped value always fits the output width, so the upper bits carry only sign.
    assign unused_hi = res.value[63:OUTBITWIDTH];
    assign sat_hit   = res.sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
            sat <= 1'b0;
        end else if (en) begin
            out <= res.value[OUTBITWIDTH-1:0];
            sat <= res.sat;
        end
    end

endmodule

// File: rtl/ddc_cmixer.sv
// Four-stage complex mixer: register inputs, form the four cross products, combine
// them for up/down conversion, then round and saturate both rails.
module ddc_cmixer
    import ddc_pkg::*;
#(
    parameter int ADBITWIDTH  = 16,
    parameter int NCOBITWIDTH = 16,
    parameter int OUTBITWIDTH = 16,
    parameter int CNTBITWIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [ADBITWIDTH-1:0]  in_i,
    input  logic signed [ADBITWIDTH-1:0]  in_q,
    input  logic signed [NCOBITWIDTH-1:0] nco_cos,
    input  logic signed [NCOBITWIDTH-1:0] nco_sin,
    input  logic                          cplx_mode,
    input  logic                          up_mode,
    input  logic                          sat_clr,
    output logic                          out_valid,
    output logic signed [OUTBITWIDTH-1:0] out_i,
    output logic signed [OUTBITWIDTH-1:0] out_q,
    output logic                          sat_flag,
    output logic [CNTBITWIDTH-1:0]        sat_count
);

    localparam int PW    = ADBITWIDTH + NCOBITWIDTH;
    localparam int SW    = PW + 1;
    localparam int SHIFT = PW - OUTBITWIDTH;

    logic                          s1_valid, s2_valid, s3_valid;
    logic signed [ADBITWIDTH-1:0]  s1_i, s1_q;
    logic signed [NCOBITWIDTH-1:0] s1_cos, s1_sin;
    mix_dir_e                      s1_dir, s2_dir;
    logic signed [PW-1:0]          s2_ic, s2_qs, s2_qc, s2_is;
    logic signed [SW-1:0]          s3_sum_i, s3_sum_q;
    logic                          hit_i, hit_q, sat_i, sat_q;

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // the previous stage's value from before the edge; blocking here would collapse stages.
    // NOTE: only the valid bits need reset to drop in-flight samples; data registers
    // are reset too so the outputs start from a defined zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1_i     <= '0;
            s1_q     <= '0;
            s1_cos   <= '0;
            s1_sin   <= '0;
            s1_dir   <= MIX_DOWN;
            s2_dir   <= MIX_DOWN;
            s2_ic    <= '0;
            s2_qs    <= '0;
            s2_qc    <= '0;
            s2_is    <= '0;
            s3_sum_i <= '0;
            s3_sum_q <= '0;
        end else begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            if (in_valid) begin
                s1_i   <= in_i;
                s1_q   <= (cplx_mode == MIX_CPLX) ? in_q : '0;
                s1_cos <= nco_cos;
                s1_sin <= nco_sin;
                s1_dir <= mix_dir_e'(up_mode);
            end
            if (s1_valid) begin
                s2_ic  <= PW'(s1_i) * PW'(s1_cos);
                s2_qs  <= PW'(s1_q) * PW'(s1_sin);
                s2_qc  <= PW'(s1_q) * PW'(s1_cos);
                s2_is  <= PW'(s1_i) * PW'(s1_sin);
                s2_dir <= s1_dir;
            end
            if (s2_valid) begin
                // Up conversion multiplies by cos+jsin, down by cos-jsin.
                if (s2_dir == MIX_UP) begin
                    s3_sum_i <= SW'(s2_ic) - SW'(s2_qs);
                    s3_sum_q <= SW'(s2_qc) + SW'(s2_is);
                end else begin
                    s3_sum_i <= SW'(s2_ic) + SW'(s2_qs);
                    s3_sum_q <= SW'(s2_qc) - SW'(s2_is);
                end
            end
        end
    end

    ddc_round_sat #(
        .SUMBITWIDTH(SW),
        .OUTBITWIDTH(OUTBITWIDTH),
        .SHIFT      (SHIFT)
    ) u_rail_i (
        .clk    (clk),
        .rst    (rst),
        .en     (s3_valid),
        .sum    (s3_sum_i),
        .out    (out_i),
        .sat_hit(hit_i),
        .sat    (sat_i)
    );

    ddc_round_sat #(
        .SUMBITWIDTH(SW),
        .OUTBITWIDTH(OUTBITWIDTH),
        .SHIFT      (SHIFT)
    ) u_rail_q (
        .clk    (clk),
        .rst    (rst),
        .en     (s3_valid),
        .sum    (s3_sum_q),
        .out    (out_q),
        .sat_hit(hit_q),
        .sat    (sat_q)
    );

    assign sat_flag = sat_i | sat_q;

    // Counter updates on the same edge as the outputs so it agrees with sat_flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sat_count <= '0;
        end else begin
            out_valid <= s3_valid;
            if (sat_clr)
                sat_count <= '0;
            else if (s3_valid && (hit_i || hit_q) && !(&sat_count))
                sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ddc_cmixer.sv
// Directed-vector bench for ddc_cmixer with hand-computed expectations (A=N=OUT=16).
module tb_ddc_cmixer;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] in_i, in_q, nco_cos, nco_sin;
    logic               cplx_mode, up_mode, sat_clr;
    logic               out_valid;
    logic signed [15:0] out_i, out_q;
    logic               sat_flag;
    logic [15:0]        sat_count;

    int n_checks = 0;
    int n_errors = 0;

    ddc_cmixer #(
        .ADBITWIDTH (16),
        .NCOBITWIDTH(16),
        .OUTBITWIDTH(16),
        .CNTBITWIDTH(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_i     (in_i),
        .in_q     (in_q),
        .nco_cos  (nco_cos),
        .nco_sin  (nco_sin),
        .cplx_mode(cplx_mode),
        .up_mode  (up_mode),
        .sat_clr  (sat_clr),
        .out_valid(out_valid),
        .out_i    (out_i),
        .out_q    (out_q),
        .sat_flag (sat_flag),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int i, input int q, input int c, input int s,
                         input logic cplx, input logic up);
        in_valid  = v;
        in_i      = 16'(i);
        in_q      = 16'(q);
        nco_cos   = 16'(c);
        nco_sin   = 16'(s);
        cplx_mode = cplx;
        up_mode   = up;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // One isolated sample, then compare the result exactly four edges later.
    task automatic run_one(input string tag, input int ei, input int eq, input logic es);
        tick();
        idle();
        for (int k = 0; k < 2; k++) tick();
        check({tag, "_early_valid"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_i"}, out_i, ei);
        check({tag, "_q"}, out_q, eq);
        check({tag, "_sat"}, sat_flag, es);
    endtask

    logic pat_valid [5];
    logic pat_up    [5];

    initial begin
        pat_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        pat_up    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst     = 1'b1;
        sat_clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_i", out_i, 0);
        check("rst_q", out_q, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_count", sat_count, 0);
        rst = 1'b0;

        // Real/down; in_q must be ignored in real mode.
        drive(1, 16384, 12345, 32767, 0, 0, 0);
        run_one("real_down", 8192, 0, 0);
        tick();
        check("hold_valid", out_valid, 0);
        check("hold_i", out_i, 8192);

        // Complex/down at full negative scale: I clamps from 32768.
        drive(1, -32768, -32768, -32768, -32768, 1, 0);
        run_one("cplx_sat", 32767, 0, 1);
        check("cplx_sat_count", sat_count, 1);

        drive(1, 0, 16384, 0, 32767, 1, 1);
        run_one("cplx_up", -8192, 0, 0);
        drive(1, 0, 16384, 0, 32767, 1, 0);
        run_one("cplx_down", 8192, 0, 0);

        // Gapped stream with per-sample mode; output at tick c+1 belongs to input c-3.
        for (int c = 0; c < 8; c++) begin
            if (c < 5)
                drive(pat_valid[c], 0, 16384, 0, 32767, 1, pat_up[c]);
            else
                idle();
            tick();
            if (c >= 3) begin
                check($sformatf("pat_valid_%0d", c - 3), out_valid, pat_valid[c-3]);
                if (pat_valid[c-3])
                    check($sformatf("pat_i_%0d", c - 3), out_i, pat_up[c-3] ? -8192 : 8192);
            end
        end
        check("pat_count", sat_count, 1);

        // Reset with three saturating samples in flight.
        drive(1, -32768, -32768, -32768, -32768, 1, 0);
        for (int k = 0; k < 3; k++) tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_count", sat_count, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("midrst_flush_%0d", k), out_valid, 0);
        end
        check("midrst_count_end", sat_count, 0);

        // Continuous saturating stream drives the counter past its maximum.
        drive(1, -32768, -32768, -32768, -32768, 1, 0);
        for (int k = 0; k < 65540; k++) tick();
        check("cnt_max", sat_count, 16'hFFFF);
        tick();
        tick();
        check("cnt_stick", sat_count, 16'hFFFF);
        check("cnt_stream_valid", out_valid, 1);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("cnt_clr", sat_count, 0);
        tick();
        check("cnt_after_clr", sat_count, 1);
        idle();
        for (int k = 0; k < 5; k++) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
